// File: rtl/multiplier_if.sv
// Operand/result handshake bundle for the sequential 64x64 multiplier.
// The slave modport is the multiplier side; the master modport is the requester side.
interface multiplier_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] prod_hi;
    logic [63:0] prod_lo;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod_hi, prod_lo
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod_hi, prod_lo
    );
endinterface

// File: rtl/multiplier.sv
// Sequential 64x64 unsigned shift-and-add multiplier (one iteration per cycle)
// built around the shared 64-bit ALU adder; full 128-bit product over valid/ready.
module adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};
endmodule

module multiplier (
    input  logic          clk,
    input  logic          rst_n,
    multiplier_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] mcand;
    logic [63:0] acc_hi;
    logic [63:0] acc_lo;
    logic [63:0] addend;
    logic [63:0] sum;
    logic        c;
    logic [6:0]  count;
    logic        accept;

    assign addend = acc_lo[0] ? mcand : '0;

    adder u_adder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs decode state only; in_valid/out_ready steer next state.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (count == 7'd63) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Adder carry shifts into acc_hi[63], so the 128-bit product never loses a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            acc_lo <= bus.b;
            acc_hi <= '0;
            count  <= '0;
        end else if (state == BUSY) begin
            acc_hi <= {c, sum[63:1]};
            acc_lo <= {sum[0], acc_lo[63:1]};
            count  <= count + 7'd1;
        end
    end

    assign bus.prod_hi = acc_hi;
    assign bus.prod_lo = acc_lo;
endmodule

// File: doc/multiplier.md
# multiplier

Sequential 64x64 unsigned shift-and-add multiplier producing a full 128-bit product. It is a consumer of the ALU `adder`: it instantiates one 64-bit `adder` and feeds the adder's `sum` and `cout` back into its accumulator on every iteration. It sits beside the adder in the ALU execute path and delivers results over a valid/ready handshake.

## Interface
Parameters: none. Width is fixed at 64 bits to match `adder`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands; high only in IDLE.
- `a` in 64: multiplicand, unsigned.
- `b` in 64: multiplier, unsigned.
- `out_valid` out 1: product valid; high only in DONE.
- `out_ready` in 1: consumer accepts the product.
- `prod_hi` out 64: product bits [127:64].
- `prod_lo` out 64: product bits [63:0].

## Operation
- Registers:
  - `mcand` [63:0]: latched `a`.
  - `acc_hi` [63:0]: accumulator, drives `prod_hi`.
  - `acc_lo` [63:0]: holds `b` and shifts in the low product bits; drives `prod_lo`.
  - `count` [6:0]: iteration counter.
  - `state`: IDLE, BUSY or DONE.
- Adder instance inputs: `a=acc_hi`, `b=acc_lo[0] ? mcand : 64'd0`, `cin=0`. The adder produces `sum` and `c`.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready`: `mcand<=a`, `acc_lo<=b`, `acc_hi<=0`, `count<=0`, go to BUSY.
- BUSY, one iteration per cycle:
  - `acc_hi <= {c, sum[63:1]}`.
  - `acc_lo <= {sum[0], acc_lo[63:1]}`.
  - `count <= count+1`.
  - Stay in BUSY while `count != 63`. The cycle with `count==63` performs the last iteration and transitions to DONE.
- DONE:
  - `out_valid=1`. `prod_hi` and `prod_lo` hold `{acc_hi, acc_lo}` = `a*b` exactly (no truncation).
  - On `out_valid & out_ready`, go to IDLE. Product registers are not cleared.
- There is no early termination. Zero operands still take 64 iterations.
- The carry out of the adder is never lost: `c` shifts into `acc_hi[63]`. The 128-bit result cannot overflow.
- `in_valid` is ignored outside IDLE. `a` and `b` are sampled only at the accept edge and may change afterwards.
- `out_ready` is ignored outside DONE.

## Timing
- Reset (async assert, independent of `clk`) sets:
  - `state=IDLE`, so `in_ready=1` and `out_valid=0`.
  - `prod_hi=0`, `prod_lo=0`, `mcand=0`, `count=0`.
- Reset asserted mid-operation (BUSY or DONE) aborts the operation. No `out_valid` is produced for it. The block is accepting again on the first edge after `rst_n` deasserts.
- Latency: operands accepted at edge N; `out_valid` rises after edge N+64 (64 BUSY cycles).
- `in_ready` and `out_valid` are pure decodes of `state`. Neither depends combinationally on `in_valid` or `out_ready`.
- Backpressure: in DONE with `out_ready=0`, `prod_*` and `out_valid` hold indefinitely.
- Throughput: the result handshake at edge M returns the block to IDLE. The earliest next accept is edge M+1, giving 66 cycles per operation with no stalls.
- Critical path: the full 64-bit ripple through `adder` plus the mux. This is acceptable and there is no pipelining inside the iteration.

## Test plan
- Basic product: `a=3`, `b=5`, accepted at edge N. Required:
  - `out_valid` rises after edge N+64.
  - `prod_hi=0`, `prod_lo=15`.
  - `in_ready=0` for all 64 BUSY cycles.
- Carry path: `a=64'h8000_0000_0000_0000`, `b=2` -> `prod_hi=1`, `prod_lo=0`.
- Maximum operands: `a=b=64'hFFFF_FFFF_FFFF_FFFF` -> `prod_hi=64'hFFFF_FFFF_FFFF_FFFE`, `prod_lo=1`.
- Zero operand with backpressure:
  - Stimulus: `a=0`, `b=64'h1234`; hold `out_ready=0` for 10 cycles after `out_valid`, with `in_valid=1` and new operands throughout.
  - Required: `out_valid` stays 1, products stay 0, the new operands are not accepted. After `out_ready=1`, IDLE follows and the next operation is accepted one edge later.
- Back-to-back random:
  - Stimulus: 200 random pairs with `in_valid` and `out_ready` held at 1.
  - Required: every `{prod_hi, prod_lo}` equals the 128-bit reference product, and results are spaced exactly 66 cycles apart.
- Reset mid-operation:
  - Stimulus: assert `rst_n=0` asynchronously (between edges) at BUSY iteration 30.
  - Required: outputs go to their reset values immediately, and no `out_valid` appears for the aborted operation. A following `7*9` yields `prod_lo=63`, `prod_hi=0`.
